// File: rtl/cmp_serial_unit.sv
// Bit-serial MSB-first comparator producing EQ/NE/LT/GE/LTU/GEU.
// One operand bit per cycle; results registered and held until next start.
module cmp_serial_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [N-1:0] d0,
  output logic [N-1:0] d1,
  output logic [N-1:0] d2,
  output logic [N-1:0] d3,
  output logic [N-1:0] d4,
  output logic [N-1:0] d5
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CTOP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          ltu;
  logic [5:0]    res;

  logic          bit_a;
  logic          bit_b;
  logic          diff;
  logic          dec_n;
  logic          ltu_n;
  logic          eq;
  logic          lts;

  // Current bit evaluation and the result bits it would finalize
  always_comb begin
    bit_a = ra[cnt];
    bit_b = rb[cnt];
    diff  = !decided && (bit_a != bit_b);
    dec_n = decided | diff;
    ltu_n = diff ? bit_b : ltu;
    eq    = ~dec_n;
    lts   = eq ? 1'b0 : (ltu_n ^ (ra[N-1] ^ rb[N-1]));
  end

  // Control FSM, operand shift state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      ltu     <= 1'b0;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra      <= a;
            rb      <= b;
            cnt     <= CTOP;
            decided <= 1'b0;
            ltu     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          decided <= dec_n;
          ltu     <= ltu_n;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            res   <= {~ltu_n, ltu_n, ~lts, lts, ~eq, eq};
            done  <= 1'b1;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign d0 = {{(N-1){1'b0}}, res[0]};
  assign d1 = {{(N-1){1'b0}}, res[1]};
  assign d2 = {{(N-1){1'b0}}, res[2]};
  assign d3 = {{(N-1){1'b0}}, res[3]};
  assign d4 = {{(N-1){1'b0}}, res[4]};
  assign d5 = {{(N-1){1'b0}}, res[5]};

endmodule

// File: tb/tb_cmp_serial_unit.sv
// Directed vector bench for cmp_serial_unit.
// Table of operands with hand-computed results plus corner sequences.
module tb_cmp_serial_unit;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         valid;
  logic [N-1:0] d0, d1, d2, d3, d4, d5;

  int total;
  int bad;

  cmp_serial_unit #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .valid(valid),
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .d3   (d3),
    .d4   (d4),
    .d5   (d5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {d5,d4,d3,d2,d1,d0} bit0 values
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] e;
  } vec_t;

  vec_t       tbl[8];
  logic [5:0] prev;

  function automatic logic [47:0] outs();
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic [47:0] expand(input logic [5:0] e);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[k*8] = e[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Run one compare; checks latency, busy, hold during RUN, results.
  task automatic do_cmp(input logic [7:0] va, input logic [7:0] vb,
                        input logic [5:0] e, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    chk({nm, " valid0"}, 64'(valid), 64'd0);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    while (!done && n < 40) begin
      chk({nm, " hold"}, 64'(outs()), 64'(expand(prev)));
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(N));
    chk({nm, " res"}, 64'(outs()), 64'(expand(e)));
    chk({nm, " vld"}, 64'({valid, busy}), 64'b10);
    prev = e;
    @(posedge clk);
    #1;
    chk({nm, " pulse"}, 64'({done, valid, busy}), 64'b010);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    prev  = '0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    tbl[0] = '{8'h05, 8'h05, 6'b101001};
    tbl[1] = '{8'h80, 8'h01, 6'b100110};
    tbl[2] = '{8'h7F, 8'hFF, 6'b011010};
    tbl[3] = '{8'h01, 8'h00, 6'b101010};
    tbl[4] = '{8'h10, 8'h20, 6'b010110};
    tbl[5] = '{8'hFF, 8'h00, 6'b100110};
    tbl[6] = '{8'h00, 8'h00, 6'b101001};
    tbl[7] = '{8'hFE, 8'hFF, 6'b010110};

    rst_n = 1'b0;
    #12;
    chk("rst outs", 64'(outs()), 64'd0);
    chk("rst flags", 64'({busy, done, valid}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_cmp(tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("v%0d", i));

    // Mid-RUN start ignored, then held start gives back-to-back
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h01;
    @(posedge clk);
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    a = 8'h05;
    b = 8'h05;
    n = 3;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid lat", 64'(n), 64'(N));
    chk("mid res", 64'(outs()), 64'(expand(6'b100110)));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk("b2b lat", 64'(n), 64'(N + 1));
    chk("b2b res", 64'(outs()), 64'(expand(6'b101001)));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b idle", 64'({done, valid, busy}), 64'b010);
    prev = 6'b101001;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    a = 8'h7F;
    b = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst flags", 64'({busy, done, valid}), 64'd0);
    chk("arst outs", 64'(outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
    do_cmp(8'h10, 8'h20, 6'b010110, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
